// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: FSM state encoding,
// default vectors and a small address-alignment helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR_DEF   = 32'h0000_0080;
  localparam int unsigned PC_STEP_DEF         = 4;
  localparam int unsigned PC_RAS_DEPTH_DEF    = 4;

  // True when addr is not a multiple of step (step is a power of two).
  function automatic logic addr_misaligned(input logic [63:0] addr, input int unsigned step);
    logic [63:0] mask;
    mask = 64'(step) - 64'd1;
    return (addr & mask) != 64'd0;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// push+pop together replaces the top entry in place.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    top_idx_s;
  logic             pop_ok_s;

  // ptr_q is the next free slot; the top entry sits just below it.
  assign top_idx_s = ptr_q - PW'(1'b1);
  assign pop_ok_s  = pop_i & (cnt_q != {CW{1'b0}});
  assign top_o     = mem_q[top_idx_s];
  assign empty_o   = (cnt_q == {CW{1'b0}});

  // Next-state of stack storage, pointer and occupancy count.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    case ({push_i, pop_ok_s})
      2'b10: begin
        mem_d[ptr_q] = push_data_i;
        ptr_d        = ptr_q + PW'(1'b1);
        cnt_d        = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1'b1);
      end
      2'b01: begin
        ptr_d = top_idx_s;
        cnt_d = cnt_q - CW'(1'b1);
      end
      2'b11: begin
        mem_d[top_idx_s] = push_data_i;
      end
      default: begin
        ptr_d = ptr_q;
      end
    endcase
  end

  // Stack state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      ptr_q <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HALT control, exception and
// redirect handling. Define PC_GEN_RAS_EN to add the return-address stack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR_DEF),
  parameter int unsigned      STEP         = PC_STEP_DEF,
  parameter int unsigned      RAS_DEPTH    = PC_RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc,
  input  logic             halt,
  input  logic             resume,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             misalign,
  output logic             ras_miss,
  output logic             ras_empty
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] seq_pc_s;
  logic             pc_valid_q;
  logic             misalign_q, misalign_d;
  logic             redirect_misaligned_s;

  assign pc_inc_s              = pc_q + WIDTH'(STEP);
  assign redirect_misaligned_s = addr_misaligned(64'(redirect_target), STEP);

`ifdef PC_GEN_RAS_EN
  logic             seq_adv_s;
  logic             ras_push_s;
  logic             ras_pop_s;
  logic             ras_empty_s;
  logic [WIDTH-1:0] ras_top_s;
  logic             ras_miss_q, ras_miss_d;

  // Call/ret only act on an edge where RUN advances sequentially.
  assign seq_adv_s  = (state_q == ST_RUN) & ~exc & ~redirect & ~halt & ~stall;
  assign ras_push_s = seq_adv_s & call;
  assign ras_pop_s  = seq_adv_s & ret & ~ras_empty_s;
  assign ras_miss_d = seq_adv_s & ret & ras_empty_s;
  assign seq_pc_s   = (ret && !ras_empty_s) ? ras_top_s : pc_inc_s;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (ras_push_s),
    .pop_i       (ras_pop_s),
    .push_data_i (pc_inc_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s)
  );

  // One-cycle pulse for a ret that found the stack empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_miss_q <= 1'b0;
    end else begin
      ras_miss_q <= ras_miss_d;
    end
  end

  assign ras_miss  = ras_miss_q;
  assign ras_empty = ras_empty_s;
`else
  logic unused_ras_s;

  assign unused_ras_s = call ^ ret;
  assign seq_pc_s     = pc_inc_s;
  assign ras_miss     = 1'b0;
  assign ras_empty    = 1'b1;
`endif

  // Control FSM and next-pc selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (exc) begin
          pc_d = EXC_VECTOR;
        end else if (redirect) begin
          if (redirect_misaligned_s) begin
            pc_d       = EXC_VECTOR;
            misalign_d = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = seq_pc_s;
        end
      end
      ST_HALT: begin
        if (exc) begin
          pc_d    = EXC_VECTOR;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State, pc and status flag registers; pc_valid tracks the RUN state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= (state_d == ST_RUN);
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then random stimulus,
// all compared against a queue-based reference model.
module tb_pc_gen;

  localparam int unsigned STEP  = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] EV    = 32'h0000_0080;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect, exc, halt, resume, call, ret;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        pc_valid, misalign, ras_miss, ras_empty;

  logic        zero1 = 1'b0;
  logic [7:0]  zero8 = 8'h00;
  logic [7:0]  pc8;
  logic        v8, mis8, miss8, empty8;

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_boot, m_halted, m_mis, m_miss;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_gen #(.WIDTH(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .STEP(STEP), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .exc(exc), .halt(halt), .resume(resume),
    .call(call), .ret(ret), .pc(pc), .pc_valid(pc_valid), .misalign(misalign),
    .ras_miss(ras_miss), .ras_empty(ras_empty)
  );

  pc_gen #(.WIDTH(8), .RESET_VECTOR(8'hF0), .EXC_VECTOR(8'h80), .STEP(4), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .reset(reset), .stall(zero1), .redirect(zero1),
    .redirect_target(zero8), .exc(zero1), .halt(zero1), .resume(zero1),
    .call(zero1), .ret(zero1), .pc(pc8), .pc_valid(v8), .misalign(mis8),
    .ras_miss(miss8), .ras_empty(empty8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_pc     = RV;
    m_mis    = 1'b0;
    m_miss   = 1'b0;
    m_ras.delete();
  endtask

  // Behaviour of one clock edge, from the documented rules.
  task automatic model_edge();
    longint nxt;
    m_mis  = 1'b0;
    m_miss = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      if (exc) begin
        m_pc = EV;
        m_halted = 1'b0;
      end else if (resume) begin
        m_halted = 1'b0;
      end
    end else if (exc) begin
      m_pc = EV;
    end else if (redirect) begin
      if (redirect_target % STEP != 0) begin
        m_pc  = EV;
        m_mis = 1'b1;
      end else begin
        m_pc = redirect_target;
      end
    end else if (halt) begin
      m_halted = 1'b1;
    end else if (!stall) begin
      nxt = (longint'(m_pc) + STEP) % (64'd1 << 32);
      if (RAS_EN && ret) begin
        if (m_ras.size() > 0) nxt = m_ras.pop_back();
        else m_miss = 1'b1;
      end
      if (RAS_EN && call) begin
        m_ras.push_back(32'((longint'(m_pc) + STEP) % (64'd1 << 32)));
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = 32'(nxt);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_valid", 32'(pc_valid), 32'(!m_boot && !m_halted));
    check("misalign", 32'(misalign), 32'(m_mis));
    check("ras_miss", 32'(ras_miss), 32'(m_miss));
    check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
  endtask

  task automatic idle();
    stall = 1'b0; redirect = 1'b0; exc = 1'b0; halt = 1'b0;
    resume = 1'b0; call = 1'b0; ret = 1'b0; redirect_target = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    idle();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    int r;
    reset = 1'b0;
    idle();
    model_reset();
    #1;
    check_all();
    tick();
    tick();
    reset = 1'b1;
    check("w8_boot", 32'(pc8), 32'h0F0);
    check("w8_boot_valid", 32'(v8), 32'h0);

    // Idle run from reset; the 8-bit instance wraps 0xFC -> 0x00.
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("w8_pc", 32'(pc8), 32'((240 + 4 * (k - 1)) % 256));
    end
    check("idle_pc", pc, 32'h10);

    // Stall two cycles, redirect on the second.
    stall = 1'b1;
    tick();
    check("stall_hold", pc, 32'h10);
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
    tick();
    check("stall_redir", pc, 32'h40);
    tick();
    check("after_redir", pc, 32'h44);

    // Misaligned redirect, then exc beating redirect.
    redirect = 1'b1; redirect_target = 32'h42;
    tick();
    check("mis_pc", pc, 32'h80);
    check("mis_flag", 32'(misalign), 32'h1);
    tick();
    check("mis_clear", 32'(misalign), 32'h0);
    exc = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
    tick();
    check("exc_redir", pc, 32'h80);

    // Halt, hold, resume; exc out of HALT; reset in HALT.
    redirect = 1'b1; redirect_target = 32'h20;
    tick();
    halt = 1'b1;
    tick();
    check("halt_valid", 32'(pc_valid), 32'h0);
    for (int k = 0; k < 3; k++) tick();
    check("halt_hold", pc, 32'h20);
    resume = 1'b1;
    tick();
    check("resume_pc", pc, 32'h20);
    tick();
    check("resume_next", pc, 32'h24);
    halt = 1'b1;
    tick();
    exc = 1'b1;
    tick();
    check("halt_exc", pc, 32'h80);
    halt = 1'b1;
    tick();
    async_reset();
    tick();
    reset = 1'b1;
    tick();
    check("post_halt_reset", pc, RV);

`ifdef PC_GEN_RAS_EN
    // Five calls into a four-deep stack, then five returns.
    for (int k = 1; k <= 5; k++) begin
      redirect = 1'b1; redirect_target = 32'(k * 16);
      tick();
      call = 1'b1;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      ret = 1'b1;
      tick();
      check("ras_ret", pc, 32'h54 - 32'(k * 16));
    end
    ret = 1'b1;
    tick();
    check("ras_miss_pc", pc, 32'h28);
    check("ras_miss_flag", 32'(ras_miss), 32'h1);
`endif

    // Random stimulus.
    for (int i = 0; i < 800; i++) begin
      reset = 1'b1;
      r = int'($urandom_range(0, 99));
      exc      = (r < 4);
      redirect = (r >= 4 && r < 16);
      redirect_target = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) redirect_target = redirect_target | 32'h2;
      stall  = ($urandom_range(0, 6) == 0);
      halt   = ($urandom_range(0, 24) == 0);
      resume = ($urandom_range(0, 3) == 0);
      call   = ($urandom_range(0, 3) == 0);
      ret    = ($urandom_range(0, 3) == 0);
      if (halt) begin
        stall = 1'b0; call = 1'b0; ret = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
